// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets and the
// state encoding used by both the TX and RX serial FSMs.
package uart_pkg;

    localparam logic [3:0] UART_TX_READY_OFF = 4'h0;
    localparam logic [3:0] UART_RX_VALID_OFF = 4'h4;
    localparam logic [3:0] UART_TX_DATA_OFF  = 4'h8;
    localparam logic [3:0] UART_RX_DATA_OFF  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_mmio_if.sv
// CPU-side strobe/address/data bundle for the UART I/O window.
interface uart_mmio_if;

    logic [3:0]  addr;
    logic        we;
    logic        re;
    logic [7:0]  wr_data;
    logic [31:0] rd_data;

    modport master (output addr, we, re, wr_data, input rd_data);
    modport slave  (input addr, we, re, wr_data, output rd_data);

endinterface

// File: rtl/uart_rx.sv
// Receive path: 2-flop synchronizer plus 8N1 deserializer emitting a byte
// with a one-cycle done pulse.
//   state | meaning
//   IDLE  | line high, waiting for a low sample
//   START | half-bit wait, then confirm start bit (high = glitch)
//   DATA  | sample 8 bits at bit centres, LSB first
//   STOP  | sample stop bit; low = framing error, byte dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_serial,
    output logic [7:0] o_byte,
    output logic       o_done
);

    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] L_FULL = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] L_HALF = CW'(SYMBOL_EDGE_TIME / 2 - 1);

    logic        r_sync1, r_sync2;
    uart_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            o_byte  <= '0;
            o_done  <= 1'b0;
        end else begin
            r_sync1 <= i_serial;
            r_sync2 <= r_sync1;
            o_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_sync2) begin
                        r_cnt   <= L_HALF;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= L_FULL;
                        r_bit   <= '0;
                        r_state <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= L_FULL;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == '0) begin
                        if (r_sync2) begin
                            o_byte <= r_shift;
                            o_done <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART responder: register decode, TX buffer + serializer,
// RX status/data registers. UART_TX_FIFO_EN swaps the TX holding register for a 4-entry FIFO.
//   state | meaning (TX)
//   IDLE  | line high, load next byte when one is buffered
//   START | start bit
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic           clk,
    input  logic           reset,
    uart_mmio_if.slave     bus,
    input  logic           serial_in,
    output logic           serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] L_FULL = CW'(SYMBOL_EDGE_TIME - 1);

    logic        w_wr_hit, w_pop_hit;
    logic        w_tx_ready, w_tx_avail, w_tx_pop;
    logic [7:0]  w_tx_head;
    logic [7:0]  w_rx_byte;
    logic        w_rx_done;

    uart_state_t   r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_rx_valid, r_overrun;
    logic [7:0]    r_rx_byte;

    assign w_wr_hit  = bus.we && (bus.addr == UART_TX_DATA_OFF);
    assign w_pop_hit = bus.re && (bus.addr == UART_RX_DATA_OFF) && r_rx_valid;
    assign w_tx_pop  = (r_tx_state == ST_IDLE) && w_tx_avail;

`ifdef UART_TX_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_fill;
    logic       w_push;

    assign w_tx_ready = (r_fill != 3'd4);
    assign w_tx_avail = (r_fill != 3'd0);
    assign w_tx_head  = r_fifo[r_rp];
    // A full FIFO still accepts a write when the FSM dequeues in the same cycle.
    assign w_push     = w_wr_hit && (w_tx_ready || w_tx_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wp] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fill <= '0;
        end else begin
            if (w_push)   r_wp <= r_wp + 2'd1;
            if (w_tx_pop) r_rp <= r_rp + 2'd1;
            case ({w_push, w_tx_pop})
                2'b10:   r_fill <= r_fill + 3'd1;
                2'b01:   r_fill <= r_fill - 3'd1;
                default: r_fill <= r_fill;
            endcase
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_hold_full;

    assign w_tx_ready = !r_hold_full;
    assign w_tx_avail = r_hold_full;
    assign w_tx_head  = r_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_tx_pop) begin
            r_hold_full <= 1'b0;
        end else if (w_wr_hit && !r_hold_full) begin
            r_hold      <= bus.wr_data;
            r_hold_full <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            serial_out <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_tx_avail) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_cnt   <= L_FULL;
                        serial_out <= 1'b0;
                        r_tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt   <= L_FULL;
                        r_tx_bit   <= '0;
                        serial_out <= r_tx_shift[0];
                        r_tx_state <= ST_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt <= L_FULL;
                        if (r_tx_bit == 3'd7) begin
                            serial_out <= 1'b1;
                            r_tx_state <= ST_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= r_tx_shift >> 1;
                            serial_out <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_tx_cnt == '0)
                        r_tx_state <= ST_IDLE;
                    else
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    uart_rx #(.SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .i_serial (serial_in),
        .o_byte   (w_rx_byte),
        .o_done   (w_rx_done)
    );

    // A pop coinciding with a completion frees the register first, so the new byte lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_rx_byte  <= '0;
        end else if (w_rx_done && (!r_rx_valid || w_pop_hit)) begin
            r_rx_byte  <= w_rx_byte;
            r_rx_valid <= 1'b1;
            r_overrun  <= 1'b0;
        end else if (w_rx_done) begin
            r_overrun  <= 1'b1;
        end else if (w_pop_hit) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            UART_TX_READY_OFF: bus.rd_data = {31'b0, w_tx_ready};
            UART_RX_VALID_OFF: bus.rd_data = {30'b0, r_overrun, r_rx_valid};
            UART_RX_DATA_OFF:  bus.rd_data = {24'b0, r_rx_byte};
            default:           bus.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at default 50 MHz / 115200 (434 cycles per bit).
module tb_uart_mmio;

    localparam int BIT = 434;
`ifdef UART_TX_FIFO_EN
    localparam logic FIFO = 1'b1;
`else
    localparam logic FIFO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic serial_in;
    logic serial_out;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    uart_mmio_if bus();

    uart_mmio dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .serial_in  (serial_in),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.rd_data;
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        bus.addr = 4'h8; bus.wr_data = d; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic pop(output logic [31:0] v);
        @(negedge clk);
        bus.addr = 4'hC; bus.re = 1'b1;
        #1;
        v = bus.rd_data;
        @(negedge clk);
        bus.re = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        @(negedge clk);
        serial_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            serial_in = b[k];
            repeat (BIT) @(negedge clk);
        end
        serial_in = stop_b;
        repeat (BIT) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic catch_frame(input int bound, output logic [7:0] b, output logic got, output int t0);
        int n;
        n = 0; got = 1'b0; b = '0; t0 = 0;
        while (serial_out !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (serial_out === 1'b0) begin
            got = 1'b1;
            t0 = cyc;
            repeat (BIT / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (BIT) @(negedge clk);
                b[k] = serial_out;
            end
            repeat (BIT) @(negedge clk);
            chk("stop_bit", {31'b0, serial_out}, 32'd1);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        int          lows;
        logic        low_seen;

        reset = 1'b1; serial_in = 1'b1;
        bus.addr = 4'h0; bus.we = 1'b0; bus.re = 1'b0; bus.wr_data = '0;
        #2 reset = 1'b0;
        #1;
        rd(4'h0, v); chk("rst_tx_ready", v, 32'd1);
        chk("rst_serial_out", {31'b0, serial_out}, 32'd1);
        rd(4'h4, v); chk("rst_status", v, 32'd0);
        rd(4'hC, v); chk("rst_rx_data", v, 32'd0);
        rd(4'h1, v); chk("rst_unmapped", v, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame 0x55 with exact start-bit length and one-cycle busy window.
        bus.addr = 4'h8; bus.wr_data = 8'h55; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
        rd(4'h0, v); chk("tx_busy_1cyc", v, 32'd0);
        chk("tx_line_before_load", {31'b0, serial_out}, 32'd1);
        @(negedge clk);
        rd(4'h0, v); chk("tx_ready_after_load", v, 32'd1);
        lows = 0;
        while (serial_out === 1'b0 && lows < 1000) begin
            lows++;
            @(negedge clk);
        end
        chk("tx_start_len", lows, BIT);
        b = '0;
        repeat (BIT / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            b[k] = serial_out;
            repeat (BIT) @(negedge clk);
        end
        chk("tx_byte_55", {24'b0, b}, 32'h55);
        chk("tx_stop_55", {31'b0, serial_out}, 32'd1);
        repeat (BIT) @(negedge clk);

        // Back-to-back 0xA1, 0x3C; 0xFF written while busy.
        fork
            begin
                logic [31:0] rv;
                wr(8'hA1);
                wr(8'h3C);
                rd(4'h0, rv); chk("tx_ready_busy", rv, {31'b0, FIFO});
                wr(8'hFF);
            end
            begin
                logic [7:0] fb;
                logic       fg;
                int         ta, tb;
                catch_frame(200, fb, fg, ta);
                chk("frame1_seen", {31'b0, fg}, 32'd1);
                chk("frame1_byte", {24'b0, fb}, 32'hA1);
                catch_frame(6000, fb, fg, tb);
                chk("frame2_seen", {31'b0, fg}, 32'd1);
                chk("frame2_byte", {24'b0, fb}, 32'h3C);
                chk("frame_gap", {31'b0, (tb - ta >= 10 * BIT) && (tb - ta <= 10 * BIT + 2)}, 32'd1);
                catch_frame(6000, fb, fg, ta);
                chk("frame3_seen", {31'b0, fg}, {31'b0, FIFO});
                if (FIFO) chk("frame3_byte", {24'b0, fb}, 32'hFF);
            end
        join
        repeat (BIT) @(negedge clk);

        // Receive 0x5A, then pop.
        send_frame(8'h5A, 1'b1);
        rd(4'h4, v); chk("rx_valid_5a", v, 32'd1);
        rd(4'hC, v); chk("rx_data_5a", v, 32'h5A);
        pop(v); chk("rx_pop_data", v, 32'h5A);
        rd(4'h4, v); chk("rx_after_pop", v, 32'd0);
        pop(v);
        rd(4'h4, v); chk("rx_empty_pop", v, 32'd0);

        // Overrun: second byte dropped.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd(4'hC, v); chk("ovr_data", v, 32'h11);
        rd(4'h4, v); chk("ovr_status", v, 32'd3);
        pop(v);
        rd(4'h4, v); chk("ovr_cleared", v, 32'd0);

        // Short glitch, then a frame with a low stop bit.
        @(negedge clk);
        serial_in = 1'b0;
        repeat (100) @(negedge clk);
        serial_in = 1'b1;
        repeat (500) @(negedge clk);
        rd(4'h4, v); chk("glitch_ignored", v, 32'd0);
        send_frame(8'h66, 1'b0);
        repeat (600) @(negedge clk);
        rd(4'h4, v); chk("framing_err", v, 32'd0);

        // Reset in the middle of a TX frame.
        wr(8'h00);
        repeat (1000) @(negedge clk);
        chk("midframe_low", {31'b0, serial_out}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_line", {31'b0, serial_out}, 32'd1);
        rd(4'h0, v); chk("async_rst_ready", v, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        low_seen = 1'b0;
        repeat (5000) begin
            @(negedge clk);
            if (serial_out !== 1'b1) low_seen = 1'b1;
        end
        chk("no_resume_after_rst", {31'b0, low_seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART responder for the CPU's I/O window at 0x8000_0000. It decodes the control unit's UART strobes (write enable, read-pop enable) and the low address bits, and returns status or received data on a read bus. It serializes transmit bytes onto `serial_out` (8N1) and deserializes `serial_in` into a one-byte receive register.

## Interface
- `CLOCK_FREQ`, 50_000_000, core clock in Hz.
- `BAUD_RATE`, 115_200, line rate. `SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE` (integer divide; 434 at defaults).
- `clk` in 1: core clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `addr` in 4: byte offset within the UART window. Decoded values are 0x0, 0x4, 0x8 and 0xC; all others are unmapped.
- `we` in 1: store strobe (WEUART).
- `re` in 1: pop strobe for the receive data register (REUART).
- `wr_data` in 8: transmit byte.
- `rd_data` out 32: combinational read data, selected by `addr`.
- `serial_in` in 1: line input; idle high.
- `serial_out` out 1: line output; idle high.

## Operation
- Register map:
  - 0x0 read: `{31'b0, tx_ready}`.
  - 0x4 read: `{30'b0, overrun, rx_valid}`.
  - 0x8 write: queue `wr_data`.
  - 0xC read: `{24'b0, rx_byte}`. When `re` is high, also pops the byte.
  - Unmapped reads return 0.
- Strobe rules:
  - `we` takes effect only when `addr`==0x8.
  - `re` takes effect only when `addr`==0xC.
  - A write while `tx_ready`=0 is dropped silently.
- TX path: holding register plus shift FSM with states IDLE, START, DATA, STOP.
  - `tx_ready` = holding register empty.
  - In IDLE with the holding register full, the FSM moves the byte into the shift register, frees the holding register and enters START.
  - Each state lasts `SYMBOL_EDGE_TIME` cycles. Data bits are sent LSB first, with a 3-bit bit counter.
  - After STOP, the FSM returns to IDLE. If the holding register is full at that point, it starts the next frame in the following cycle, with no extra idle bit.
- RX path: `serial_in` passes through a 2-flop synchronizer. The FSM has states IDLE, START, DATA, STOP.
  - IDLE: a low sample enters START.
  - START: wait `SYMBOL_EDGE_TIME/2` cycles, then re-sample. Still low means go to DATA; high means a glitch, return to IDLE.
  - DATA: sample 8 bits at bit centres, LSB first.
  - STOP: sample at centre. High means the frame is complete. Low means a framing error: the byte is discarded and the FSM returns to IDLE.
- Frame completion:
  - `rx_valid`=0: load `rx_byte` and set `rx_valid`.
  - `rx_valid`=1: drop the new byte, keep `rx_byte` and set `overrun` (sticky).
  - A pop in the same cycle as a completion clears first. The new byte loads and `rx_valid` stays 1.
- A pop clears `rx_valid` and `overrun`. A pop while `rx_valid`=0 has no effect.

## Timing
- Reset values:
  - `serial_out`=1, `tx_ready`=1, `rx_valid`=0, `overrun`=0, `rx_byte`=0.
  - Both FSMs in IDLE, all counters 0.
  - `rd_data` follows `addr` combinationally (0x0 reads 1).
- Reset asserted mid-frame aborts immediately. `serial_out` returns high asynchronously.
- Write accepted at edge N:
  - `tx_ready`=0 after edge N.
  - The FSM loads at edge N+1: `serial_out` falls and `tx_ready` returns to 1.
  - The frame is 10×`SYMBOL_EDGE_TIME` cycles.
- Read latency is 0 cycles: `rd_data` is valid in the same cycle as `addr`. A pop takes effect at the next edge.
- `rx_valid` rises one cycle after the stop-bit centre sample. Synchronizer latency of 2 cycles is included before the START detect.

## Configuration
- `UART_TX_FIFO_EN` defined: the holding register is replaced by a 4-entry TX FIFO.
  - `tx_ready` = !full.
  - Writes enqueue; the FSM dequeues in IDLE.
  - Back-to-back frames continue without gaps while the FIFO is non-empty.
  - A write and a dequeue in the same cycle when full are both performed, with occupancy unchanged.
- Undefined: single holding register as described above.

## Structure
- Package `uart_pkg` holds:
  - Offset constants `UART_TX_READY_OFF`=4'h0, `UART_RX_VALID_OFF`=4'h4, `UART_TX_DATA_OFF`=4'h8, `UART_RX_DATA_OFF`=4'hC.
  - Shared FSM state typedef (IDLE, START, DATA, STOP).
- One sub-module, `uart_rx`: synchronizer plus RX FSM. It outputs a byte and a one-cycle `done` pulse. The `rx_valid`, `overrun` and pop logic stay in the top module.

## Test plan
- Reset with `addr`=0x0 → `rd_data`=1 and `serial_out`=1. `addr`=0x4 → 0.
- Write 0x55 at 0x8 → `serial_out` low for 434 cycles from the next edge, then bits 1,0,1,0,1,0,1,0 LSB first, then high. `tx_ready` is 0 for exactly 1 cycle.
- Write 0xA1 then 0x3C on consecutive eligible cycles, then write 0xFF while `tx_ready`=0 → 0xA1 and 0x3C are sent back-to-back, 0xFF never appears. With `UART_TX_FIFO_EN`, all three are sent.
- Drive frame 0x5A on `serial_in` → `rx_valid`=1 and 0xC reads 0x0000005A. A pop clears `rx_valid` next cycle.
- Two frames 0x11 then 0x22 with no pop → 0xC reads 0x11 and 0x4 reads 3. After a pop it reads 0.
- A 100-cycle low glitch, then a frame with a low stop bit → `rx_valid` stays 0. Reset asserted mid-TX frame → `serial_out`=1 immediately.
